mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- HI/LO multiply/divide unit for the P6 pipelined MIPS core.
- Sits beside the EX-stage ALU. It is the responder side of the core's mult/div issue handshake: the core issues an operation and the unit computes it over multiple cycles.
- While `start` or `busy` is high, the core stalls any mult/div/mfhi/mflo/mthi/mtlo in ID.
- Results appear on `hi`/`lo` when the operation completes.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (must be ≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (must be ≥1)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  issue pulse for the operation on `op` (one cycle, from the EX stage)
- op  input  2  operation: 0=mult, 1=multu, 2=div, 3=divu
- a  input  32  rs operand (multiplicand / dividend)
- b  input  32  rt operand (multiplier / divisor)
- hi_we  input  1  mthi: write `a` into HI
- lo_we  input  1  mtlo: write `a` into LO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse in the cycle HI/LO take the new result
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset is asynchronous and active-high. On reset: `busy`=0, `done`=0, `hi`=0, `lo`=0, state=IDLE, counter=0.
- States: IDLE and BUSY.
- IDLE, `start`=1:
  - latch `op`, `a`, `b`;
  - load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3);
  - go to BUSY.
- `busy` timing: `busy` rises on the edge that samples `start`. It stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- BUSY: the counter decrements every cycle. On the edge where the counter goes 1→0:
  - HI/LO load the result;
  - `busy`→0;
  - `done`=1 for that one cycle;
  - state returns to IDLE.
- Latency: with `start` at edge k, HI/LO are valid and `busy`=0 after edge k+N. `done` is high during cycle k+N.
- Back-to-back: a `start` in the cycle `done`=1 is accepted (state is IDLE then).
- Result computation (the result may be computed at issue and held; only the visible timing is fixed):
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: lo = unsigned quotient; hi = unsigned remainder.
  - div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor 0 (div/divu): timing is unchanged (`busy` N cycles, `done` pulses), but HI and LO keep their previous values.
- mthi/mtlo:
  - In IDLE with `start`=0: `hi_we` loads `a` into HI and `lo_we` loads `a` into LO at the edge. Both may be asserted together.
  - `hi_we`/`lo_we` are ignored while `busy`=1 or `start`=1; `start` has priority.
- Protocol violations: `start` while `busy`=1 is ignored. The latched operands and the countdown are not disturbed.
- `hi`/`lo` hold their old values throughout BUSY and change only at completion, reset, or mthi/mtlo.
- Reset mid-operation: the operation is aborted immediately. All outputs take their reset values, and no `done` pulse is produced.

Test Plan:
- Reset, then start op=0, a=0xFFFFFFFE (-2), b=3 -> `busy` high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, `done` one cycle.
- op=1, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- op=2, a=0xFFFFFFF9 (-7), b=2 -> `busy` 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Edge cases:
  - op=2, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Then op=3 with b=0 -> `busy` 10 cycles, `done` pulses, hi/lo unchanged.
- Interference during an operation:
  - In IDLE pulse `hi_we` with a=0x12345678 -> hi=0x12345678.
  - Start multu 2×3, then pulse `lo_we` and a second `start` (op=3) while busy -> both ignored; final hi=0, lo=6, `busy` exactly 5 cycles.
- Start div, assert `reset` asynchronously at cycle 4 (between clock edges) -> `busy`, `done`, `hi`, `lo` go to 0 immediately, with no later `done`. A new start after reset release completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the pipelined MIPS core.
// The result is computed when the operation is issued and committed to HI/LO after a fixed countdown.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   res_hi;
   logic [31:0]   res_lo;
   logic          res_we;

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        safe_b;
   logic               ovf;
   logic [31:0]        q_s, r_s, q_u, r_u;
   logic [31:0]        nxt_hi, nxt_lo;
   logic               nxt_we;

   // Divisor is forced to 1 for zero and for the signed overflow case so the
   // divider never sees an undefined or trapping input; both cases are fixed up below.
   always_comb begin
      prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u = {32'd0, a} * {32'd0, b};
      ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      safe_b = ((b == 32'd0) || ovf) ? 32'd1 : b;
      q_s    = ovf ? 32'h8000_0000 : $unsigned($signed(a) / $signed(safe_b));
      r_s    = ovf ? 32'd0 : $unsigned($signed(a) % $signed(safe_b));
      q_u    = a / safe_b;
      r_u    = a % safe_b;
      nxt_hi = 32'd0;
      nxt_lo = 32'd0;
      nxt_we = 1'b1;
      case (op)
         2'd0: begin nxt_hi = prod_s[63:32]; nxt_lo = prod_s[31:0]; end
         2'd1: begin nxt_hi = prod_u[63:32]; nxt_lo = prod_u[31:0]; end
         2'd2: begin nxt_hi = r_s; nxt_lo = q_s; nxt_we = (b != 32'd0); end
         default: begin nxt_hi = r_u; nxt_lo = q_u; nxt_we = (b != 32'd0); end
      endcase
   end

   assign busy = (state == BUSY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         done   <= 1'b0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
         res_we <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               state  <= BUSY;
               cnt    <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               res_hi <= nxt_hi;
               res_lo <= nxt_lo;
               res_we <= nxt_we;
            end else begin
               if (hi_we) hi <= a;
               if (lo_we) lo <= a;
            end
         end else begin
            // start, hi_we and lo_we are all ignored while counting down.
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state <= IDLE;
               done  <= 1'b1;
               if (res_we) begin
                  hi <= res_hi;
                  lo <= res_lo;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issues directed operations, a monitor
// checks HI/LO and busy length at every done pulse.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_pass   = 0;
   int run      = 0;
   logic prev_done = 1'b0;

   // Each entry: {expected busy length, expected hi, expected lo}
   logic [95:0] exp_q[$];

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Called at a negedge; returns at the next negedge with the operation in flight.
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int len);
      exp_q.push_back({len[31:0], eh, el});
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns at the negedge of the first cycle with busy low (the done cycle).
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         run       = 0;
         prev_done = 1'b0;
      end else begin
         if (busy) run++;
         if (done) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
               check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
               logic [95:0] e;
               e = exp_q.pop_front();
               check("hi", hi, e[63:32]);
               check("lo", lo, e[31:0]);
               check("busy_len", run[31:0], e[95:64]);
            end
            run = 0;
         end
         prev_done = done;
      end
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 2'd0;
      a     = 32'd0;
      b     = 32'd0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      issue(2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      check("hold_mid_busy", hi, 32'd0);
      wait_idle();
      @(negedge clk);
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
      wait_idle();
      @(negedge clk);
      issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      wait_idle();
      @(negedge clk);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
      wait_idle();
      @(negedge clk);
      issue(2'd3, 32'd1234, 32'd0, 32'd0, 32'h8000_0000, 10);
      wait_idle();
      @(negedge clk);

      hi_we = 1'b1;
      lo_we = 1'b1;
      a     = 32'hCAFE_F00D;
      @(negedge clk);
      lo_we = 1'b0;
      a     = 32'h1234_5678;
      check("mt_both_hi", hi, 32'hCAFE_F00D);
      check("mt_both_lo", lo, 32'hCAFE_F00D);
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi", hi, 32'h1234_5678);
      check("mthi_lo_kept", lo, 32'hCAFE_F00D);

      // start beats a simultaneous mthi; mtlo and a second start while busy are dropped.
      hi_we = 1'b1;
      issue(2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 5);
      hi_we = 1'b0;
      check("start_prio_hi", hi, 32'h1234_5678);
      lo_we = 1'b1;
      start = 1'b1;
      op    = 2'd3;
      a     = 32'h0000_DEAD;
      b     = 32'd1;
      @(negedge clk);
      start = 1'b0;
      lo_we = 1'b0;
      check("mtlo_ignored", lo, 32'hCAFE_F00D);
      wait_idle();

      // Back-to-back: the next start lands in the done cycle.
      @(negedge clk);
      issue(2'd1, 32'd4, 32'd5, 32'd0, 32'd20, 5);
      wait_idle();
      issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
      wait_idle();
      @(negedge clk);

      // Abort a div with an asynchronous reset between clock edges.
      start = 1'b1;
      op    = 2'd2;
      a     = 32'd100;
      b     = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_abort_busy", {31'd0, busy}, 32'd0);
      repeat (15) @(negedge clk);

      issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
      wait_idle();
      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
